// File: rtl/passcode_entry_if.sv
// passcode_entry_if: keypad, state-manager and result signals of the passcode entry block
interface passcode_entry_if;
    logic       key_press;
    logic [3:0] key_code;
    logic [2:0] state;
    logic       is_on;
    logic       is_star_pressed;
    logic       correct;
    logic [3:0] digit_count;
    modport master (output key_press, key_code, state, input is_on, is_star_pressed, correct, digit_count);
    modport slave (input key_press, key_code, state, output is_on, is_star_pressed, correct, digit_count);
endinterface

// File: rtl/passcode_entry.sv
// passcode_entry: keypad entry buffer and stored passcode for the door lock; PASSCODE_BACKSPACE_EN enables key 12 as backspace
module passcode_entry #(
    parameter int          MAX_DIGITS   = 8,
    parameter int          MIN_DIGITS   = 4,
    parameter logic [31:0] DEFAULT_CODE = 32'h0000_1234,
    parameter int          DEFAULT_LEN  = 4
) (
    input logic clk,
    input logic reset_n,
    passcode_entry_if.slave bus
);
    localparam int W = 4 * MAX_DIGITS;
    localparam logic [3:0] MAX_C = 4'(MAX_DIGITS);
    localparam logic [3:0] MIN_C = 4'(MIN_DIGITS);
    localparam logic [3:0] LEN_C = 4'(DEFAULT_LEN);
    logic [W-1:0] buf_q, buf_n, code_q;
    logic [3:0]   cnt_q, cnt_n, len_q;
    logic [2:0]   prev_q;
    logic         on_q, star_q, correct_q, correct_n;
    logic         changed, into_off, entry_st, key_digit, key_star, key_hash, key_bs, capture;
    // key decode, buffer next value and comparison result
    always_comb begin
        changed   = bus.state != prev_q;
        into_off  = changed && bus.state == 3'b000;
        entry_st  = bus.state inside {3'b001, 3'b010, 3'b011, 3'b101};
        key_digit = bus.key_press && bus.key_code <= 4'd9 && entry_st && cnt_q < MAX_C;
        key_star  = bus.key_press && bus.key_code == 4'd10 && bus.state != 3'b111;
        key_hash  = bus.key_press && bus.key_code == 4'd11 && bus.state != 3'b111 && !into_off;
`ifdef PASSCODE_BACKSPACE_EN
        key_bs    = bus.key_press && bus.key_code == 4'd12 && entry_st && cnt_q != 4'd0 && !star_q;
`else
        key_bs    = 1'b0;
`endif
        capture   = key_star && bus.state == 3'b101 && cnt_q >= MIN_C;
        buf_n     = (key_star || changed) ? '0 :
                    key_digit ? {buf_q[W-5:0], bus.key_code} :
                    key_bs ? {4'd0, buf_q[W-1:4]} : buf_q;
        cnt_n     = (key_star || changed) ? 4'd0 :
                    key_digit ? cnt_q + 4'd1 :
                    key_bs ? cnt_q - 4'd1 : cnt_q;
        correct_n = bus.state inside {3'b001, 3'b010, 3'b011} ? (cnt_q == len_q && buf_q == code_q) :
                    bus.state == 3'b101 ? cnt_q >= MIN_C : 1'b0;
    end
    // registered outputs, entry buffer and stored passcode
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buf_q     <= '0;
            cnt_q     <= 4'd0;
            code_q    <= W'(DEFAULT_CODE);
            len_q     <= LEN_C;
            prev_q    <= 3'b000;
            on_q      <= 1'b0;
            star_q    <= 1'b0;
            correct_q <= 1'b0;
        end else begin
            buf_q     <= buf_n;
            cnt_q     <= cnt_n;
            prev_q    <= bus.state;
            star_q    <= key_star;
            correct_q <= key_star ? correct_q : correct_n;
            on_q      <= into_off ? 1'b0 : key_hash ? !on_q : on_q;
            if (capture) begin
                code_q <= buf_q;
                len_q  <= cnt_q;
            end
        end
    end
    assign bus.is_on           = on_q;
    assign bus.is_star_pressed = star_q;
    assign bus.correct         = correct_q;
    assign bus.digit_count     = cnt_q;
endmodule

// File: tb/tb_passcode_entry.sv
// tb_passcode_entry: directed vector table plus hand sequences for passcode_entry
module tb_passcode_entry;
    typedef struct {
        logic       p;
        logic [3:0] k;
        logic [2:0] s;
        logic       on;
        logic       st;
        logic       c;
        logic [3:0] n;
    } vec_t;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    vec_t vec[$];
    passcode_entry_if bus ();
    passcode_entry dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input int idx, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0d, expected %0d", nm, idx, got, exp);
        end
    endtask
    task automatic add(input logic p, input logic [3:0] k, input logic [2:0] s,
                       input logic on, input logic st, input logic c, input logic [3:0] n);
        vec_t v;
        v.p = p; v.k = k; v.s = s; v.on = on; v.st = st; v.c = c; v.n = n;
        vec.push_back(v);
    endtask
    task automatic step(input int idx, input logic p, input logic [3:0] k, input logic [2:0] s,
                        input logic on, input logic st, input logic c, input logic [3:0] n);
        bus.key_press = p;
        bus.key_code  = k;
        bus.state     = s;
        @(posedge clk);
        #1;
        chk("is_on", idx, {3'd0, bus.is_on}, {3'd0, on});
        chk("is_star_pressed", idx, {3'd0, bus.is_star_pressed}, {3'd0, st});
        chk("correct", idx, {3'd0, bus.correct}, {3'd0, c});
        chk("digit_count", idx, bus.digit_count, n);
    endtask
    initial begin
        add(1, 11, 0, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0);
        add(1, 1, 1, 1, 0, 0, 1); add(1, 2, 1, 1, 0, 0, 2); add(1, 3, 1, 1, 0, 0, 3); add(1, 4, 1, 1, 0, 0, 4);
        add(0, 0, 1, 1, 0, 1, 4);
        add(1, 10, 1, 1, 1, 1, 0);
        add(0, 0, 1, 1, 0, 0, 0);
        add(1, 1, 1, 1, 0, 0, 1); add(1, 2, 1, 1, 0, 0, 2); add(1, 3, 1, 1, 0, 0, 3);
        add(0, 0, 1, 1, 0, 0, 3);
        add(1, 10, 1, 1, 1, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0);
        add(1, 1, 1, 1, 0, 0, 1); add(1, 2, 1, 1, 0, 0, 2); add(1, 3, 1, 1, 0, 0, 3); add(1, 4, 1, 1, 0, 0, 4);
        add(1, 5, 1, 1, 0, 1, 5);
        add(0, 0, 1, 1, 0, 0, 5);
        add(1, 10, 1, 1, 1, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 5, 1, 0, 0, 0);
        add(1, 9, 5, 1, 0, 0, 1); add(1, 8, 5, 1, 0, 0, 2); add(1, 7, 5, 1, 0, 0, 3);
        add(0, 0, 5, 1, 0, 0, 3);
        add(1, 6, 5, 1, 0, 0, 4);
        add(0, 0, 5, 1, 0, 1, 4);
        add(1, 10, 5, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(1, 11, 0, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0);
        add(1, 9, 1, 1, 0, 0, 1); add(1, 8, 1, 1, 0, 0, 2); add(1, 7, 1, 1, 0, 0, 3); add(1, 6, 1, 1, 0, 0, 4);
        add(0, 0, 1, 1, 0, 1, 4);
        add(1, 10, 1, 1, 1, 1, 0);
        add(0, 0, 1, 1, 0, 0, 0);
        add(1, 1, 1, 1, 0, 0, 1); add(1, 2, 1, 1, 0, 0, 2); add(1, 3, 1, 1, 0, 0, 3); add(1, 4, 1, 1, 0, 0, 4);
        add(0, 0, 1, 1, 0, 0, 4);
        add(1, 10, 1, 1, 1, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(1, 4'((i + 1) % 10), 1, 1, 0, 0, (i < 8) ? 4'(i + 1) : 4'd8);
        add(0, 0, 1, 1, 0, 0, 8);
        add(1, 10, 1, 1, 1, 0, 0);
        add(1, 1, 1, 1, 0, 0, 1);
        add(1, 2, 2, 1, 0, 0, 0);
        add(0, 0, 2, 1, 0, 0, 0);
        add(0, 0, 7, 1, 0, 0, 0);
        add(1, 5, 7, 1, 0, 0, 0);
        add(1, 11, 7, 1, 0, 0, 0);
        add(1, 10, 7, 1, 0, 0, 0);
        add(0, 0, 7, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0);
        bus.key_press = 1'b0;
        bus.key_code  = 4'd0;
        bus.state     = 3'b000;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset is_on", 0, {3'd0, bus.is_on}, 4'd0);
        chk("reset star", 0, {3'd0, bus.is_star_pressed}, 4'd0);
        chk("reset correct", 0, {3'd0, bus.correct}, 4'd0);
        chk("reset count", 0, bus.digit_count, 4'd0);
        reset_n = 1'b1;
        foreach (vec[i]) step(i, vec[i].p, vec[i].k, vec[i].s, vec[i].on, vec[i].st, vec[i].c, vec[i].n);
        step(100, 1, 1, 1, 1, 0, 0, 1);
        step(101, 1, 2, 1, 1, 0, 0, 2);
        reset_n = 1'b0;
        step(102, 0, 0, 1, 0, 0, 0, 0);
        reset_n = 1'b1;
        step(103, 0, 0, 5, 0, 0, 0, 0);
        step(104, 1, 1, 5, 0, 0, 0, 1);
        step(105, 1, 2, 5, 0, 0, 0, 2);
        step(106, 1, 3, 5, 0, 0, 0, 3);
        step(107, 0, 0, 5, 0, 0, 0, 3);
        step(108, 1, 10, 5, 0, 1, 0, 0);
        step(109, 0, 0, 1, 0, 0, 0, 0);
        step(110, 1, 1, 1, 0, 0, 0, 1);
        step(111, 1, 2, 1, 0, 0, 0, 2);
        step(112, 1, 3, 1, 0, 0, 0, 3);
        step(113, 1, 4, 1, 0, 0, 0, 4);
        step(114, 0, 0, 1, 0, 0, 1, 4);
        step(115, 1, 13, 1, 0, 0, 1, 4);
`ifdef PASSCODE_BACKSPACE_EN
        step(116, 1, 12, 1, 0, 0, 1, 3);
        step(117, 0, 0, 1, 0, 0, 0, 3);
        step(118, 1, 5, 1, 0, 0, 0, 4);
        step(119, 0, 0, 1, 0, 0, 0, 4);
        step(120, 1, 12, 1, 0, 0, 0, 3);
        step(121, 1, 4, 1, 0, 0, 0, 4);
        step(122, 0, 0, 1, 0, 0, 1, 4);
        step(123, 1, 10, 1, 0, 1, 1, 0);
        step(124, 0, 0, 1, 0, 0, 0, 0);
        step(125, 1, 12, 1, 0, 0, 0, 0);
`else
        step(116, 1, 12, 1, 0, 0, 1, 4);
        step(117, 0, 0, 1, 0, 0, 1, 4);
`endif
        bus.key_press = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/passcode_entry.md
Name: passcode_entry

Overview:
- Upstream keypad front end for the door-lock state manager.
- Collects digit keystrokes into an entry buffer and holds the stored passcode.
- Produces the `is_on`, `is_star_pressed` and `correct` inputs of the state manager, and uses its 3-bit `state` to choose between compare mode and new-passcode capture mode.
- State encoding: 000 off, 001 on, 010 wrong1, 011 wrong2, 100 answer, 101 reset, 111 lock.

Parameters:
- MAX_DIGITS, 8, capacity of the entry buffer and the longest passcode.
- MIN_DIGITS, 4, shortest passcode accepted when capturing a new one.
- DEFAULT_CODE, 32'h0000_1234, passcode loaded at reset. Packed 4-bit BCD, least-significant nibble is the last digit.
- DEFAULT_LEN, 4, length of DEFAULT_CODE in digits.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  synchronous, active-low reset.
- key_press  input  1  one-cycle pulse per debounced keystroke.
- key_code  input  4  0-9 digit, 10 star, 11 hash, 12-15 reserved. Valid only with key_press.
- state  input  3  current state from the state manager.
- is_on  output  1  power toggle (registered).
- is_star_pressed  output  1  one-cycle star pulse (registered).
- correct  output  1  compare or capture result (registered).
- digit_count  output  4  number of digits currently in the entry buffer.

Behaviour:
- Reset (reset_n=0 at posedge):
  - is_on=0, is_star_pressed=0, correct=0, digit_count=0, buffer cleared.
  - stored code = DEFAULT_CODE, stored length = DEFAULT_LEN.
  - Reset mid-entry discards the partial entry.
- Key decode happens only when key_press=1.
  - Reserved codes are ignored.
  - All keys are ignored while state==111 (lock).
- Digit key (states 001, 010, 011, 101):
  - Shift the digit into the buffer LSB nibble, count+1.
  - At count==MAX_DIGITS, further digits are dropped and count saturates.
  - Digits in states 000 and 100 are ignored.
- Hash key: toggles is_on in any state except 111.
- Star key:
  - is_star_pressed=1 for exactly one cycle, the cycle after the key_press edge.
  - The buffer is cleared on that same edge.
  - correct holds its pre-star value through that cycle.
  - Star is therefore sampled by the downstream negedge together with a valid correct.
- correct: registered, recomputed every cycle except the star cycle.
  - States 001/010/011: correct=1 iff count==stored length and the low count nibbles of the buffer equal the stored code.
  - State 101: correct=1 iff count>=MIN_DIGITS.
  - Other states: correct=0.
- Capture: on star in state 101 with count>=MIN_DIGITS, the buffer and count are copied into the stored code and length on the same edge. A star with fewer digits does not change the stored code.
- State change:
  - A registered prev_state is kept.
  - When state != prev_state, the buffer is cleared, so the next cycle sees correct=0.
  - On a transition into 000 from any other state, is_on is forced to 0 so the lock does not immediately re-enter on.
  - A hash pressed in that same cycle is ignored.
- Simultaneous events: a state-change clear takes priority over a digit in the same cycle (the digit is dropped); star-capture takes priority over the clear.
- The stored passcode is never exposed on a port.

Optional Feature:
- Macro: PASSCODE_BACKSPACE_EN.
- Defined: key_code 12 removes the last digit (buffer shifts right one nibble, count-1). It is ignored when count==0, in states 000/100/111, and during the star cycle. correct updates the next cycle.
- Undefined: code 12 is reserved and ignored like 13-15.

Test Plan:
- Reset, then hash -> is_on=1 next cycle. Drive state=001, enter 1,2,3,4, then star -> correct=1 during the is_star_pressed cycle; digit_count=0 after it.
- In state 001, enter 1,2,3 then star -> correct=0 and is_star_pressed=1 for one cycle. Same with 1,2,3,4,5 -> correct=0.
- Drive state=101, enter 9,8,7 -> correct=0. Enter 6 -> correct=1. Star, then state=000 -> is_on=0. Hash, state=001, enter 9,8,7,6, star -> correct=1; the old code 1,2,3,4 now gives correct=0.
- Enter 10 digits in state 001 -> digit_count saturates at 8 and correct=0. State 001->010 mid-entry -> digit_count=0 the next cycle.
- state=111: digits, hash and star -> no output change; is_on stays 1 and is_star_pressed stays 0.
- With PASSCODE_BACKSPACE_EN: in state 001, enter 1,2,3,5, backspace, 4, star -> correct=1. Backspace at count 0 -> digit_count stays 0.
